sram_ptr_gen: RTL and testbench

SRAM_PTR_GEN -- requirements
Module: sram_ptr_gen

---
 rtl/sram_ptr_pkg.sv | 17 +
 rtl/sram_ptr_step.sv | 24 ++
 rtl/sram_ptr_gen.sv | 111 +++++++++++
 tb/tb_sram_ptr_gen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ptr_pkg.sv
// sram_ptr_pkg: register offsets, CTRL/STATUS bit positions and reset constants for sram_ptr_gen.
package sram_ptr_pkg;
   typedef enum logic [2:0] {
      OFF_PTR      = 3'd0,
      OFF_BASE     = 3'd1,
      OFF_LIMIT    = 3'd2,
      OFF_CTRL     = 3'd3,
      OFF_STATUS   = 3'd4,
      OFF_IRQ_MASK = 3'd5
   } reg_off_e;
   localparam int CTRL_EN         = 0;
   localparam int CTRL_WRAP       = 1;
   localparam int CTRL_STRIDE_LSB = 8;
   localparam int ST_WRAPPED      = 0;
   localparam int ST_DONE         = 1;
   localparam int STRIDE_RST      = 1;
endpackage

// File: rtl/sram_ptr_step.sv
// sram_ptr_step: combinational next-pointer / wrap / done decision for one advance.
module sram_ptr_step #(
   parameter int ADDR_W   = 20,
   parameter int STRIDE_W = 8
) (
   input  logic [ADDR_W-1:0]   i_ptr,
   input  logic [ADDR_W-1:0]   i_base,
   input  logic [ADDR_W-1:0]   i_limit,
   input  logic [STRIDE_W-1:0] i_stride,
   input  logic                i_wrap,
   output logic [ADDR_W-1:0]   o_ptr,
   output logic                o_wrapped,
   output logic                o_done
);
   // One bit wider than either operand so the sum can never alias back below LIMIT.
   localparam int NW = (ADDR_W > STRIDE_W ? ADDR_W : STRIDE_W) + 1;
   logic [NW-1:0] w_next;
   logic          w_over;
   assign w_next    = NW'(i_ptr) + NW'(i_stride);
   assign w_over    = w_next > NW'(i_limit);
   assign o_ptr     = w_over ? (i_wrap ? i_base : i_ptr) : w_next[ADDR_W-1:0];
   assign o_wrapped = w_over & i_wrap;
   assign o_done    = w_over & ~i_wrap;
endmodule

// File: rtl/sram_ptr_gen.sv
// sram_ptr_gen: Avalon-MM programmable SRAM address pointer with stride, limit and wrap.
// Define SRAM_PTR_IRQ_EN to add IRQ_MASK and the registered irq output.
module sram_ptr_gen
   import sram_ptr_pkg::*;
#(
   parameter int ADDR_W   = 20,
   parameter int STRIDE_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic              adv_valid,
   output logic              adv_ready,
   output logic [ADDR_W-1:0] out_port
`ifdef SRAM_PTR_IRQ_EN
   ,
   output logic              irq
`endif
);
   logic [ADDR_W-1:0]   r_ptr, r_base, r_limit;
   logic [STRIDE_W-1:0] r_stride;
   logic                r_en, r_wrap, r_wrapped, r_done;
   logic                w_wr, w_wr_ptr, w_wr_st, w_fire;
   logic [ADDR_W-1:0]   w_step_ptr;
   logic                w_step_wrapped, w_step_done;
   logic [1:0]          w_irq_mask;
   logic                w_unused;

   assign w_wr      = chipselect & ~write_n;
   assign w_wr_ptr  = w_wr & (address == OFF_PTR);
   assign w_wr_st   = w_wr & (address == OFF_STATUS);
   // Any write to offsets 0-3 changes the step inputs, so hold off advances that cycle.
   assign adv_ready = r_en & ~r_done & ~(w_wr & ~address[2]);
   assign w_fire    = adv_valid & adv_ready;
   assign out_port  = r_ptr;
   assign w_unused  = ^writedata;

   sram_ptr_step #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_step (
      .i_ptr     (r_ptr),
      .i_base    (r_base),
      .i_limit   (r_limit),
      .i_stride  (r_stride),
      .i_wrap    (r_wrap),
      .o_ptr     (w_step_ptr),
      .o_wrapped (w_step_wrapped),
      .o_done    (w_step_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr     <= '0;
         r_base    <= '0;
         r_limit   <= '0;
         r_en      <= 1'b0;
         r_wrap    <= 1'b0;
         r_stride  <= STRIDE_W'(STRIDE_RST);
         r_wrapped <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_fire) r_ptr <= w_step_ptr;
         if (w_wr_ptr) r_ptr <= writedata[ADDR_W-1:0];
         if (w_wr && address == OFF_BASE) r_base <= writedata[ADDR_W-1:0];
         if (w_wr && address == OFF_LIMIT) r_limit <= writedata[ADDR_W-1:0];
         if (w_wr && address == OFF_CTRL) begin
            r_en     <= writedata[CTRL_EN];
            r_wrap   <= writedata[CTRL_WRAP];
            r_stride <= writedata[CTRL_STRIDE_LSB +: STRIDE_W];
         end
         // A same-cycle set beats a W1C clear.
         r_wrapped <= (w_fire & w_step_wrapped) | (r_wrapped & ~(w_wr_st & writedata[ST_WRAPPED]));
         r_done    <= (w_fire & w_step_done) | (r_done & ~(w_wr_st & writedata[ST_DONE]) & ~w_wr_ptr);
      end
   end

`ifdef SRAM_PTR_IRQ_EN
   logic [1:0] r_irq_mask;
   logic       r_irq;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= 2'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && address == OFF_IRQ_MASK) r_irq_mask <= writedata[1:0];
         r_irq <= |({r_done, r_wrapped} & r_irq_mask);
      end
   end
   assign w_irq_mask = r_irq_mask;
   assign irq        = r_irq;
`else
   assign w_irq_mask = 2'b0;
`endif

   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            OFF_PTR:      readdata = 32'(r_ptr);
            OFF_BASE:     readdata = 32'(r_base);
            OFF_LIMIT:    readdata = 32'(r_limit);
            OFF_CTRL:     readdata = 32'({r_stride, 6'b0, r_wrap, r_en});
            OFF_STATUS:   readdata = 32'({r_en & ~r_done, r_done, r_wrapped});
            OFF_IRQ_MASK: readdata = 32'(w_irq_mask);
            default:      readdata = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_ptr_gen.sv
// tb_sram_ptr_gen: register-table vectors, directed corner sequences and a randomized
// run against an arithmetic reference model of sram_ptr_gen (ADDR_W=20, STRIDE_W=8).
module tb_sram_ptr_gen;
   localparam longint MASK = 64'hFFFFF;
`ifdef SRAM_PTR_IRQ_EN
   localparam logic [31:0] IRQM_EXP = 32'h3;
`else
   localparam logic [31:0] IRQM_EXP = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        adv_valid = 1'b0;
   logic        adv_ready;
   logic [19:0] out_port;
   logic        irq;
   int          total = 0;
   int          bad = 0;

   sram_ptr_gen #(.ADDR_W(20), .STRIDE_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .adv_valid  (adv_valid),
      .adv_ready  (adv_ready),
      .out_port   (out_port)
`ifdef SRAM_PTR_IRQ_EN
      ,
      .irq        (irq)
`endif
   );
`ifndef SRAM_PTR_IRQ_EN
   assign irq = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      #1 d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic fire();
      @(negedge clk);
      adv_valid = 1'b1;
      @(negedge clk);
      adv_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1 chk("rst_ready", 32'(adv_ready), 0);
      chk("rst_irq", 32'(irq), 0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic setup(input logic [31:0] ctrl);
      do_reset();
      wr(3'd1, 32'h10);
      wr(3'd2, 32'h1F);
      wr(3'd0, 32'h10);
      wr(3'd3, ctrl);
   endtask

   typedef struct {
      logic [2:0]  a;
      logic        we;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   // Reference model state
   longint m_ptr, m_base, m_limit, m_stride;
   bit     m_en, m_wrap, m_wrapped, m_done, m_irq;
   bit [1:0] m_mask;

   function automatic logic [31:0] mreg(input int a);
      case (a)
         0: return 32'(m_ptr);
         1: return 32'(m_base);
         2: return 32'(m_limit);
         3: return 32'(m_stride * 256 + (m_wrap ? 2 : 0) + (m_en ? 1 : 0));
         4: return 32'((m_en && !m_done ? 4 : 0) + (m_done ? 2 : 0) + (m_wrapped ? 1 : 0));
         5: return 32'(m_mask);
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      vec_t        tv[20];
      logic [31:0] r;
      logic [19:0] exp5[5];
      logic [19:0] exp4[4];
      tv[0]  = '{3'd0, 1'b0, 32'h0, 32'h0};
      tv[1]  = '{3'd1, 1'b0, 32'h0, 32'h0};
      tv[2]  = '{3'd2, 1'b0, 32'h0, 32'h0};
      tv[3]  = '{3'd3, 1'b0, 32'h0, 32'h100};
      tv[4]  = '{3'd4, 1'b0, 32'h0, 32'h0};
      tv[5]  = '{3'd5, 1'b0, 32'h0, 32'h0};
      tv[6]  = '{3'd6, 1'b0, 32'h0, 32'h0};
      tv[7]  = '{3'd7, 1'b0, 32'h0, 32'h0};
      tv[8]  = '{3'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFF};
      tv[9]  = '{3'd2, 1'b1, 32'h12345678, 32'h45678};
      tv[10] = '{3'd0, 1'b1, 32'h00ABCDEF, 32'hBCDEF};
      tv[11] = '{3'd3, 1'b1, 32'hFFFFFFFC, 32'hFF00};
      tv[12] = '{3'd6, 1'b1, 32'hFFFFFFFF, 32'h0};
      tv[13] = '{3'd7, 1'b1, 32'hFFFFFFFF, 32'h0};
      tv[14] = '{3'd5, 1'b1, 32'hFFFFFFFF, IRQM_EXP};
      tv[15] = '{3'd4, 1'b1, 32'h7, 32'h0};
      tv[16] = '{3'd3, 1'b1, 32'h201, 32'h201};
      tv[17] = '{3'd4, 1'b0, 32'h0, 32'h4};
      tv[18] = '{3'd5, 1'b1, 32'h0, 32'h0};
      tv[19] = '{3'd3, 1'b1, 32'h100, 32'h100};

      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      chk("rst_port", 32'(out_port), 0);
      for (int i = 0; i < 20; i++) begin
         if (tv[i].we) wr(tv[i].a, tv[i].d);
         rd(tv[i].a, r);
         chk($sformatf("tv%0d", i), r, tv[i].exp);
      end
      address = 3'd3;
      #1 chk("cs_low", readdata, 0);

      // wrap run
      exp5 = '{20'h14, 20'h18, 20'h1C, 20'h10, 20'h14};
      setup(32'h403);
      for (int k = 0; k < 5; k++) begin
         fire();
         chk($sformatf("wrap_port%0d", k), 32'(out_port), 32'(exp5[k]));
         if (k == 2) begin rd(3'd4, r); chk("wrap_st_pre", r, 32'h4); end
         if (k == 3) begin rd(3'd4, r); chk("wrap_st_post", r, 32'h5); end
      end

      // done run, then PTR write reopens
      exp4 = '{20'h14, 20'h18, 20'h1C, 20'h1C};
      setup(32'h401);
      for (int k = 0; k < 4; k++) begin
         fire();
         chk($sformatf("done_port%0d", k), 32'(out_port), 32'(exp4[k]));
      end
      rd(3'd4, r);
      chk("done_st", r, 32'h2);
      chk("done_ready", 32'(adv_ready), 0);
      wr(3'd0, 32'h10);
      rd(3'd4, r);
      chk("reload_st", r, 32'h4);
      chk("reload_ready", 32'(adv_ready), 1);
      chk("reload_port", 32'(out_port), 32'h10);

      // advance blocked by a same-cycle LIMIT write, taken the cycle after
      @(negedge clk);
      adv_valid = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h1F;
      #1 chk("blk_ready", 32'(adv_ready), 0);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      chk("blk_port", 32'(out_port), 32'h10);
      #1 chk("blk_ready_next", 32'(adv_ready), 1);
      @(negedge clk);
      adv_valid = 1'b0;
      chk("blk_taken", 32'(out_port), 32'h14);

      // top-of-range wrap without truncation
      do_reset();
      wr(3'd2, 32'hFFFFF);
      wr(3'd0, 32'hFFFFF);
      wr(3'd1, 32'h0);
      wr(3'd3, 32'h103);
      fire();
      chk("top_port", 32'(out_port), 0);
      rd(3'd4, r);
      chk("top_st", r, 32'h5);

      // set and W1C in the same cycle: set wins
      wr(3'd0, 32'hFFFFF);
      @(negedge clk);
      adv_valid = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'h1;
      #1 chk("w1c_ready", 32'(adv_ready), 1);
      @(negedge clk);
      adv_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      rd(3'd4, r);
      chk("w1c_set_wins", r, 32'h5);
      wr(3'd4, 32'h1);
      rd(3'd4, r);
      chk("w1c_clear", r, 32'h4);

      // stride 0
      wr(3'd3, 32'h003);
      fire();
      chk("s0_port", 32'(out_port), 0);
      rd(3'd4, r);
      chk("s0_st", r, 32'h4);
      wr(3'd2, 32'h5);
      wr(3'd0, 32'h8);
      fire();
      chk("s0_over_port", 32'(out_port), 0);
      rd(3'd4, r);
      chk("s0_over_st", r, 32'h5);

      // asynchronous reset during an advance
      setup(32'h403);
      @(negedge clk);
      adv_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1 chk("arst_port", 32'(out_port), 0);
      chk("arst_ready", 32'(adv_ready), 0);
      @(posedge clk);
      #1 chk("arst_hold", 32'(out_port), 0);
      @(negedge clk);
      reset_n = 1'b1; adv_valid = 1'b0;
      rd(3'd3, r);
      chk("arst_ctrl", r, 32'h100);

`ifdef SRAM_PTR_IRQ_EN
      setup(32'h401);
      wr(3'd5, 32'h2);
      repeat (4) fire();
      chk("irq_lag", 32'(irq), 0);
      @(negedge clk);
      chk("irq_set", 32'(irq), 1);
      wr(3'd4, 32'h2);
      @(negedge clk);
      chk("irq_clr", 32'(irq), 0);
      repeat (4) fire();
      @(negedge clk);
      chk("irq_set2", 32'(irq), 1);
      #2 reset_n = 1'b0;
      #1 chk("irq_rst", 32'(irq), 0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(3'd5, r);
      chk("irq_mask_rst", r, 0);
      rd(3'd4, r);
      chk("irq_st_rst", r, 0);
`endif

      // randomized run against the reference model
      do_reset();
      m_ptr = 0; m_base = 0; m_limit = 0; m_stride = 1;
      m_en = 0; m_wrap = 0; m_wrapped = 0; m_done = 0; m_irq = 0; m_mask = 0;
      for (int c = 0; c < 3000; c++) begin
         int     op, a;
         bit     av, cs, we, fr, set_w, set_d;
         logic [31:0] d;
         longint nx;
         @(negedge clk);
         av = $urandom_range(0, 3) != 0;
         op = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, 7));
         cs = op < 4;
         we = op < 2;
         d  = (a < 3) ? 32'($urandom_range(0, 80)) :
              (a == 3) ? 32'(($urandom_range(0, 5) << 8) | ($urandom_range(0, 1) << 1) |
                             ($urandom_range(0, 3) != 0 ? 1 : 0)) :
              (a == 4) ? 32'($urandom_range(0, 7)) : $urandom();
         adv_valid = av; chipselect = cs; write_n = !we; address = 3'(a); writedata = d;
         #1;
         chk("rnd_ready", 32'(adv_ready), 32'(m_en && !m_done && !(we && a < 4)));
         chk("rnd_rdata", readdata, cs ? mreg(a) : 32'h0);
         fr = av && m_en && !m_done && !(we && a < 4);
         set_w = 0; set_d = 0;
         if (fr) begin
            nx = m_ptr + m_stride;
            if (nx <= m_limit) m_ptr = nx;
            else if (m_wrap) begin m_ptr = m_base; set_w = 1; end
            else set_d = 1;
         end
         m_irq = (m_done && m_mask[1]) || (m_wrapped && m_mask[0]);
`ifndef SRAM_PTR_IRQ_EN
         m_irq = 0;
`endif
         if (we) begin
            case (a)
               0: m_ptr = longint'(d) & MASK;
               1: m_base = longint'(d) & MASK;
               2: m_limit = longint'(d) & MASK;
               3: begin m_en = d[0]; m_wrap = d[1]; m_stride = longint'(d[15:8]); end
`ifdef SRAM_PTR_IRQ_EN
               5: m_mask = d[1:0];
`endif
               default: ;
            endcase
         end
         m_wrapped = set_w || (m_wrapped && !(we && a == 4 && d[0]));
         m_done    = set_d || (m_done && !(we && a == 4 && d[1]) && !(we && a == 0));
         @(posedge clk);
         #1 chk("rnd_port", 32'(out_port), 32'(m_ptr));
         chk("rnd_irq", 32'(irq), 32'(m_irq));
      end
      @(negedge clk);
      adv_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
